pulse_gen: RTL

- Inverse of the start-signal edge detector: turns a one-cycle trigger pulse back into a timed level.
- Takes a one-clock start pulse, waits a programmable delay, then drives a level high for a programmable number of cycles.
- Sits downstream of control logic that issues single-cycle commands. Drives enables and strobes that need a defined-width level.
- All outputs are registered.

---
 rtl/pulse_gen_if.sv | 26 ++
 rtl/pulse_gen.sv | 119 +++++++++++
 2 files changed

// File: rtl/pulse_gen_if.sv
// Command/status bundle for pulse_gen: single-cycle start/stop commands in,
// registered level/busy/done (plus FSM state for observation) out.
interface pulse_gen_if #(
    parameter int CNT_W = 8
);
    // i_Start/i_Stop are level-sampled on every rising edge with no ready back-pressure.
    // A start is taken only when o_Busy is low, and a stop is meaningful only when o_Busy is high.
    logic             i_Start;
    logic             i_Stop;
    logic [CNT_W-1:0] i_Delay;
    logic [CNT_W-1:0] i_Width;
    logic             o_Level;
    logic             o_Busy;
    logic             o_Done;
    logic [1:0]       dbg_state;

    modport master (
        output i_Start, i_Stop, i_Delay, i_Width,
        input  o_Level, o_Busy, o_Done, dbg_state
    );

    modport slave (
        input  i_Start, i_Stop, i_Delay, i_Width,
        output o_Level, o_Busy, o_Done, dbg_state
    );
endinterface

// File: rtl/pulse_gen.sv
// Start-pulse to timed-level generator: programmable delay, then a level of programmable width.
// Optional macro PULSE_GEN_RETRIGGER_EN: a start while the level is high reloads the width.
module pulse_gen #(
    parameter int CNT_W = 8
) (
    input  logic       i_Clk,
    input  logic       i_Rstb,
    pulse_gen_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DELAY = 2'd1;
    localparam logic [1:0] HIGH  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] dly_cnt, dly_nxt;
    logic [CNT_W-1:0] wid_cnt, wid_nxt;
    logic [CNT_W-1:0] wid_lat, wid_lat_nxt;
    logic             level, busy, done, done_nxt;
    logic             accept;

    // Stop always wins over a simultaneous start.
    assign accept = bus.i_Start & ~bus.i_Stop;

    always_comb begin
        state_nxt   = state;
        dly_nxt     = dly_cnt;
        wid_nxt     = wid_cnt;
        wid_lat_nxt = wid_lat;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    wid_lat_nxt = bus.i_Width;
                    if (bus.i_Delay != '0) begin
                        state_nxt = DELAY;
                        dly_nxt   = bus.i_Delay;
                    end else if (bus.i_Width != '0) begin
                        state_nxt = HIGH;
                        wid_nxt   = bus.i_Width;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (bus.i_Stop) begin
                    state_nxt = IDLE;
                    dly_nxt   = '0;
                end else if (dly_cnt <= CNT_W'(1)) begin
                    dly_nxt = '0;
                    if (wid_lat != '0) begin
                        state_nxt = HIGH;
                        wid_nxt   = wid_lat;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    dly_nxt = dly_cnt - CNT_W'(1);
                end
            end
            HIGH: begin
                if (bus.i_Stop) begin
                    state_nxt = IDLE;
                    wid_nxt   = '0;
                end
`ifdef PULSE_GEN_RETRIGGER_EN
                else if (bus.i_Start) begin
                    // Reload counts from the next cycle; a zero width ends the pulse now.
                    if (bus.i_Width != '0) begin
                        wid_nxt = bus.i_Width;
                    end else begin
                        state_nxt = IDLE;
                        wid_nxt   = '0;
                        done_nxt  = 1'b1;
                    end
                end
`endif
                else if (wid_cnt <= CNT_W'(1)) begin
                    state_nxt = IDLE;
                    wid_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    wid_nxt = wid_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                dly_nxt   = '0;
                wid_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rstb) begin
        if (!i_Rstb) begin
            state   <= IDLE;
            dly_cnt <= '0;
            wid_cnt <= '0;
            wid_lat <= '0;
            level   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            dly_cnt <= dly_nxt;
            wid_cnt <= wid_nxt;
            wid_lat <= wid_lat_nxt;
            level   <= (state_nxt == HIGH);
            busy    <= (state_nxt != IDLE);
            done    <= done_nxt;
        end
    end

    assign bus.o_Level   = level;
    assign bus.o_Busy    = busy;
    assign bus.o_Done    = done;
    assign bus.dbg_state = state;
endmodule
